// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared constants for the sprite ROM arbiter: ROM geometry, the number of
// mole holes that read sprites, and the per-hole requester id encoding.
package sprite_rom_arbiter_pkg;

  localparam int ROM_AW         = 15;
  localparam int ROM_DW         = 12;
  localparam int SPRITE_ROM_LAT = 1;
  localparam int NUM_HOLES      = 4;
  localparam int HOLE_IDW       = 2;

  // Requester id of each hole renderer as seen on rd_id.
  typedef enum logic [HOLE_IDW-1:0] {
    HOLE_0 = 2'd0,
    HOLE_1 = 2'd1,
    HOLE_2 = 2'd2,
    HOLE_3 = 2'd3
  } hole_id_e;

  // Modular add used for round-robin index arithmetic (base < n, off <= n).
  function automatic int wrap_add(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    if (sum >= n) begin
      sum = sum - n;
    end else begin
      sum = sum + 0;
    end
    return sum;
  endfunction

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Requester-side bus of the sprite ROM arbiter: read requests with their
// addresses, the one-hot grant, and the tagged read return.
interface sprite_rom_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 15,
  parameter int DW   = 12,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ-1:0]    gnt;
  logic               rd_valid;
  logic [IDW-1:0]     rd_id;
  logic [DW-1:0]      rd_data;

  modport master (output req, output addr, input gnt,
                  input rd_valid, input rd_id, input rd_data);
  modport slave  (input req, input addr, output gnt,
                  output rd_valid, output rd_id, output rd_data);
endinterface

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: scans req upward from ptr, wrapping,
// and reports the first set bit as a one-hot grant plus its index.
module sprite_rom_arbiter_rr_pick
  import sprite_rom_arbiter_pkg::*;
#(
  parameter int NREQ = NUM_HOLES,
  parameter int IDW  = HOLE_IDW
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [IDW-1:0] cand_s;

  // First requesting index at or after ptr wins; later hits are ignored.
  always_comb begin
    gnt    = '0;
    idx    = '0;
    any    = 1'b0;
    cand_s = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand_s = IDW'(wrap_add(int'(ptr), off, NREQ));
      if (!any && req[cand_s]) begin
        gnt[cand_s] = 1'b1;
        idx         = cand_s;
        any         = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one clocked sprite ROM among the hole
// renderers. A grant registers the winner's address to the ROM and pushes
// its id down a tag pipeline that lines up with the ROM read latency, so
// the returned pixel comes back tagged with its owner.
module sprite_rom_arbiter
  import sprite_rom_arbiter_pkg::*;
#(
  parameter int NREQ    = NUM_HOLES,
  parameter int AW      = ROM_AW,
  parameter int DW      = ROM_DW,
  parameter int ROM_LAT = SPRITE_ROM_LAT,
  parameter int IDW     = HOLE_IDW
) (
  input  logic                 clk,
  input  logic                 rst,
  sprite_rom_arbiter_if.slave  bus,
  output logic [AW-1:0]        rom_addr,
  input  logic [DW-1:0]        rom_data
);

  logic [NREQ-1:0] pick_gnt_s;
  logic [IDW-1:0]  pick_idx_s;
  logic            pick_any_s;
  logic            grant_s;
  logic [AW-1:0]   win_addr_s;

  logic [IDW-1:0]  ptr_r;
  logic [AW-1:0]   rom_addr_r;
  logic [ROM_LAT:0] pipe_valid_r;
  logic [IDW-1:0]  pipe_id_r [ROM_LAT+1];
  logic            rd_valid_r;
  logic [IDW-1:0]  rd_id_r;
  logic [DW-1:0]   rd_data_r;

  sprite_rom_arbiter_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req (bus.req),
    .ptr (ptr_r),
    .gnt (pick_gnt_s),
    .idx (pick_idx_s),
    .any (pick_any_s)
  );

  // Grant is suppressed while reset is asserted; winner address is muxed out.
  always_comb begin
    win_addr_s = bus.addr[int'(pick_idx_s)*AW +: AW];
    if (rst) begin
      bus.gnt = '0;
      grant_s = 1'b0;
    end else begin
      bus.gnt = pick_gnt_s;
      grant_s = pick_any_s;
    end
  end

  // Pointer, ROM address, tag pipeline and read-return registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r        <= '0;
      rom_addr_r   <= '0;
      pipe_valid_r <= '0;
      for (int i = 0; i <= ROM_LAT; i++) begin
        pipe_id_r[i] <= '0;
      end
      rd_valid_r   <= 1'b0;
      rd_id_r      <= '0;
      rd_data_r    <= '0;
    end else begin
      if (grant_s) begin
        rom_addr_r <= win_addr_s;
        ptr_r      <= IDW'(wrap_add(int'(pick_idx_s), 1, NREQ));
      end else begin
        rom_addr_r <= rom_addr_r;
        ptr_r      <= ptr_r;
      end
      pipe_valid_r[0] <= grant_s;
      pipe_id_r[0]    <= pick_idx_s;
      for (int i = 1; i <= ROM_LAT; i++) begin
        pipe_valid_r[i] <= pipe_valid_r[i-1];
        pipe_id_r[i]    <= pipe_id_r[i-1];
      end
      rd_valid_r <= pipe_valid_r[ROM_LAT];
      if (pipe_valid_r[ROM_LAT]) begin
        rd_id_r   <= pipe_id_r[ROM_LAT];
        rd_data_r <= rom_data;
      end else begin
        rd_id_r   <= rd_id_r;
        rd_data_r <= rd_data_r;
      end
    end
  end

  assign rom_addr     = rom_addr_r;
  assign bus.rd_valid = rd_valid_r;
  assign bus.rd_id    = rd_id_r;
  assign bus.rd_data  = rd_data_r;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: directed scenarios followed by
// randomized requester traffic, all compared against a cycle-level model.
module tb_sprite_rom_arbiter;
  import sprite_rom_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int AW = 15;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;

  sprite_rom_arbiter_if #(.NREQ(N), .AW(AW), .DW(DW), .IDW(2)) bus ();

  sprite_rom_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  always #5 clk = ~clk;

  // Sprite ROM contents: 12'hABC at 15'h1234, a scrambled pattern elsewhere.
  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    logic [AW-1:0] m;
    if (a == 15'h1234) return 12'hABC;
    m = (a * 15'd13) ^ (a >> 4) ^ 15'h05A3;
    return m[DW-1:0];
  endfunction

  // One-cycle clocked ROM.
  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit known = 1'b0;

  // Reference model state.
  int            m_ptr;
  int            m_win;
  logic [AW-1:0] m_rom_addr;
  logic [1:0]    m_last_id;
  logic [DW-1:0] m_last_data;
  bit            exp_v [int];
  int            exp_id [int];
  logic [DW-1:0] exp_d [int];

  // Observed values of the most recent cycle.
  logic [N-1:0]  o_gnt;
  logic [AW-1:0] o_ra;
  logic          o_rv;
  logic [1:0]    o_id;
  logic [DW-1:0] o_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [N*AW-1:0] pk(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                         input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  // Drive one clock cycle, compare every output against the model, advance the model.
  task automatic cycle(input logic [N-1:0] r, input logic [N*AW-1:0] a, input logic rs);
    logic [N-1:0] eg;
    int k;
    bus.req  = r;
    bus.addr = a;
    rst      = rs;
    #4;
    o_gnt = bus.gnt;
    o_ra  = rom_addr;
    o_rv  = bus.rd_valid;
    o_id  = bus.rd_id;
    o_d   = bus.rd_data;
    m_win = -1;
    if (!rs) begin
      for (int o = 0; o < N; o++) begin
        k = (m_ptr + o) % N;
        if (m_win < 0 && r[k]) m_win = k;
      end
    end
    eg = '0;
    if (m_win >= 0) eg[m_win] = 1'b1;
    chk("gnt", 32'(o_gnt), 32'(eg));
    if (known) begin
      chk("rom_addr", 32'(o_ra), 32'(m_rom_addr));
      if (exp_v.exists(cyc)) begin
        chk("rd_valid", 32'(o_rv), 32'd1);
        chk("rd_id", 32'(o_id), 32'(exp_id[cyc]));
        chk("rd_data", 32'(o_d), 32'(exp_d[cyc]));
        m_last_id   = 2'(exp_id[cyc]);
        m_last_data = exp_d[cyc];
        exp_v.delete(cyc);
      end else begin
        chk("rd_valid_idle", 32'(o_rv), 32'd0);
        chk("rd_id_hold", 32'(o_id), 32'(m_last_id));
        chk("rd_data_hold", 32'(o_d), 32'(m_last_data));
      end
    end
    if (rs) begin
      m_ptr       = 0;
      m_rom_addr  = '0;
      m_last_id   = '0;
      m_last_data = '0;
      exp_v.delete();
      exp_id.delete();
      exp_d.delete();
      known = 1'b1;
    end else if (m_win >= 0) begin
      m_rom_addr       = a[m_win*AW +: AW];
      m_ptr            = (m_win + 1) % N;
      exp_v[cyc + 3]   = 1'b1;
      exp_id[cyc + 3]  = m_win;
      exp_d[cyc + 3]   = rom_fn(a[m_win*AW +: AW]);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  logic [N-1:0]    rq;
  logic [AW-1:0]   ra [N];
  logic [N*AW-1:0] fa;
  logic            rsr;

  // Directed scenarios, then randomized protocol-respecting traffic.
  initial begin
    bus.req  = '0;
    bus.addr = '0;
    rst      = 1'b1;
    @(posedge clk);
    #1;

    // Reset held two cycles with every requester asserting.
    cycle(4'b1111, pk(15'd1, 15'd2, 15'd3, 15'd4), 1'b1);
    chk("rst_gnt0", 32'(o_gnt), 32'd0);
    cycle(4'b1111, pk(15'd1, 15'd2, 15'd3, 15'd4), 1'b1);
    chk("rst_gnt1", 32'(o_gnt), 32'd0);
    chk("rst_rom_addr", 32'(o_ra), 32'd0);
    chk("rst_rd_valid", 32'(o_rv), 32'd0);
    cycle(4'b1111, pk(15'd1, 15'd2, 15'd3, 15'd4), 1'b0);
    chk("rst_first_gnt", 32'(o_gnt), 32'h1);
    for (int i = 0; i < 4; i++) cycle(4'b0000, '0, 1'b0);

    // Single read by requester 2.
    cycle(4'b0100, pk(15'd0, 15'd0, 15'h1234, 15'd0), 1'b0);
    chk("single_gnt", 32'(o_gnt), 32'h4);
    cycle(4'b0000, '0, 1'b0);
    chk("single_rom_addr", 32'(o_ra), 32'h1234);
    cycle(4'b0000, '0, 1'b0);
    cycle(4'b0000, '0, 1'b0);
    chk("single_rv", 32'(o_rv), 32'd1);
    chk("single_id", 32'(o_id), 32'd2);
    chk("single_data", 32'(o_d), 32'hABC);
    cycle(4'b0000, '0, 1'b0);
    chk("single_rv_off", 32'(o_rv), 32'd0);

    // Bring the pointer back to 0 by granting requester 3.
    cycle(4'b1000, pk(15'd0, 15'd0, 15'd0, 15'h0333), 1'b0);
    for (int i = 0; i < 3; i++) cycle(4'b0000, '0, 1'b0);

    // Full contention for 8 cycles.
    for (int j = 0; j < 11; j++) begin
      cycle((j < 8) ? 4'b1111 : 4'b0000, pk(15'd0, 15'd16, 15'd32, 15'd48), 1'b0);
      if (j < 8) chk("rot_gnt", 32'(o_gnt), 32'(1 << (j % 4)));
      if (j >= 3) begin
        chk("rot_rv", 32'(o_rv), 32'd1);
        chk("rot_id", 32'(o_id), 32'((j - 3) % 4));
        chk("rot_data", 32'(o_d), 32'(rom_fn(15'(((j - 3) % 4) * 16))));
      end
    end
    cycle(4'b0000, '0, 1'b0);

    // Pointer skip and wrap.
    cycle(4'b0010, pk(15'd5, 15'd6, 15'd7, 15'd8), 1'b0);
    chk("skip_gnt1", 32'(o_gnt), 32'h2);
    cycle(4'b0001, pk(15'd5, 15'd6, 15'd7, 15'd8), 1'b0);
    chk("skip_wrap", 32'(o_gnt), 32'h1);
    cycle(4'b1001, pk(15'd9, 15'd6, 15'd7, 15'd8), 1'b0);
    chk("skip_gnt3", 32'(o_gnt), 32'h8);
    for (int i = 0; i < 3; i++) cycle(4'b0000, '0, 1'b0);

    // Idle gaps between grants.
    cycle(4'b1000, pk(15'd0, 15'd0, 15'd0, 15'h7ABC), 1'b0);
    chk("idle_gnt3", 32'(o_gnt), 32'h8);
    cycle(4'b0000, '0, 1'b0);
    chk("idle_hold1", 32'(o_ra), 32'h7ABC);
    cycle(4'b0000, '0, 1'b0);
    chk("idle_hold2", 32'(o_ra), 32'h7ABC);
    cycle(4'b0001, pk(15'h0111, 15'd0, 15'd0, 15'd0), 1'b0);
    chk("idle_gnt0", 32'(o_gnt), 32'h1);
    chk("idle_rv_a", 32'(o_rv), 32'd1);
    chk("idle_id_a", 32'(o_id), 32'd3);
    cycle(4'b0000, '0, 1'b0);
    chk("idle_rv_b", 32'(o_rv), 32'd0);
    cycle(4'b0000, '0, 1'b0);
    chk("idle_rv_c", 32'(o_rv), 32'd0);
    cycle(4'b0000, '0, 1'b0);
    chk("idle_rv_d", 32'(o_rv), 32'd1);
    chk("idle_id_d", 32'(o_id), 32'd0);
    chk("idle_data_d", 32'(o_d), 32'(rom_fn(15'h0111)));

    // Reset while a read is in flight.
    cycle(4'b0010, pk(15'd0, 15'h2222, 15'd0, 15'd0), 1'b0);
    chk("mid_gnt1", 32'(o_gnt), 32'h2);
    cycle(4'b0011, pk(15'h10, 15'h20, 15'd0, 15'd0), 1'b1);
    chk("mid_rst_gnt", 32'(o_gnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle(4'b0000, '0, 1'b0);
      chk("mid_no_rv", 32'(o_rv), 32'd0);
    end
    cycle(4'b0011, pk(15'h10, 15'h20, 15'd0, 15'd0), 1'b0);
    chk("mid_after_gnt", 32'(o_gnt), 32'h1);
    for (int i = 0; i < 3; i++) cycle(4'b0000, '0, 1'b0);

    // Randomized traffic: granted requesters drop or re-issue, others hold.
    rq = '0;
    for (int i = 0; i < N; i++) ra[i] = '0;
    for (int c = 0; c < 400; c++) begin
      rsr = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < N; i++) fa[i*AW +: AW] = ra[i];
      cycle(rq, fa, rsr);
      for (int i = 0; i < N; i++) begin
        if (m_win == i) begin
          if ($urandom_range(0, 1) == 0) rq[i] = 1'b0;
          else ra[i] = 15'($urandom);
        end else if (!rq[i] && $urandom_range(0, 2) == 0) begin
          rq[i] = 1'b1;
          ra[i] = 15'($urandom);
        end
      end
    end
    for (int i = 0; i < 4; i++) cycle(4'b0000, '0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
